// File: rtl/axis_ascon_aead128_roundtrip_checker_if.sv
// AXI-Stream bundle used for the monitored and pass-through streams of the
// Ascon-AEAD128 round-trip checker.
interface axis_ascon_aead128_roundtrip_checker_if #(
    parameter int DW = 128
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DW-1:0]     tdata;
    logic [DW/8-1:0]   tkeep;

    modport master  (output tvalid, output tlast, output tdata, output tkeep, input tready);
    modport slave   (input tvalid, input tlast, input tdata, input tkeep, output tready);
    modport monitor (input tvalid, input tready, input tlast, input tdata, input tkeep);
endinterface

// File: rtl/axis_ascon_aead128_roundtrip_checker.sv
// Ascon-AEAD128 round-trip checker: passes ciphertext from encryptor to
// decryptor (optionally corrupting the first byte of a message), records the
// plaintext entering the encryptor and compares it with the decryptor output,
// then scores each message on the decryptor's tag verdict.

// Small FIFO with same-cycle bypass when empty; reports drop/underflow events.
module axis_ascon_aead128_roundtrip_checker_fifo #(
    parameter int W  = 1,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         overflow,
    output logic         underflow
);
    localparam int         DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          empty_s;
    logic          full_s;
    logic          bypass_s;
    logic          wr_en_s;
    logic          rd_en_s;

    // Decode occupancy, bypass, drop and underflow conditions for this cycle.
    always_comb begin
        empty_s   = (count_r == {(AW+1){1'b0}});
        full_s    = (count_r == FULL_CNT);
        bypass_s  = empty_s && push && pop;
        underflow = pop && empty_s && !push;
        overflow  = push && full_s && !pop;
        wr_en_s   = push && !bypass_s && !overflow;
        rd_en_s   = pop && !empty_s;
        if (!empty_s) begin
            head_data = mem_r[rd_ptr_r];
        end else if (push) begin
            head_data = push_data;
        end else begin
            head_data = {W{1'b0}};
        end
    end

    // Storage array; contents are meaningless once pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module axis_ascon_aead128_roundtrip_checker #(
    parameter int DW         = 128,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 16
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    axis_ascon_aead128_roundtrip_checker_if.monitor mon_p,
    axis_ascon_aead128_roundtrip_checker_if.slave   s_c,
    axis_ascon_aead128_roundtrip_checker_if.master  m_c,
    axis_ascon_aead128_roundtrip_checker_if.monitor mon_d,
    input  logic                                   mon_tag_tvalid,
    input  logic                                   mon_tag_tready,
    input  logic [127:0]                           mon_tag_tdata,
    input  logic                                   inj_req,
    input  logic [7:0]                             inj_mask,
    output logic [CNT_W-1:0]                       pass_cnt,
    output logic [CNT_W-1:0]                       fail_cnt,
    output logic                                   sb_overflow,
    output logic                                   sb_underflow
);
    localparam int               KW      = DW / 8;
    localparam int               SBW     = 1 + DW + KW;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        C_IDLE = 1'b0,
        C_BODY = 1'b1
    } c_state_t;

    c_state_t       c_state_r;
    c_state_t       c_state_s;
    logic           inj_pending_r;
    logic [7:0]     mask_r;
    logic           msg_bad_r;

    logic           c_hs_s;
    logic           first_hs_s;
    logic           corrupt_s;
    logic           flag_in_s;
    logic           p_hs_s;
    logic           d_hs_s;
    logic           tag_hs_s;
    logic [SBW-1:0] sb_head_s;
    logic           sb_ovf_s;
    logic           sb_und_s;
    logic           flag_head_s;
    logic           fl_ovf_s;
    logic           fl_und_s;
    logic           mismatch_s;
    logic           tag_pass_s;

    // True when the expected beat and the observed beat disagree in tlast,
    // tkeep, or any byte the expected beat marks as valid.
    function automatic logic beat_differs(input logic [SBW-1:0] exp_beat,
                                          input logic           last,
                                          input logic [DW-1:0]  data,
                                          input logic [KW-1:0]  keep);
        logic diff;
        diff = (exp_beat[SBW-1] != last) || (exp_beat[KW-1:0] != keep);
        for (int i = 0; i < KW; i++) begin
            diff = diff | (exp_beat[i] & (exp_beat[KW + 8*i +: 8] != data[8*i +: 8]));
        end
        return diff;
    endfunction

    assign c_hs_s     = s_c.tvalid && m_c.tready;
    assign first_hs_s = c_hs_s && (c_state_r == C_IDLE);
    assign corrupt_s  = (c_state_r == C_IDLE) && inj_pending_r && (mask_r != 8'h00);
    assign flag_in_s  = inj_pending_r && (mask_r != 8'h00);
    assign p_hs_s     = mon_p.tvalid && mon_p.tready;
    assign d_hs_s     = mon_d.tvalid && mon_d.tready;
    assign tag_hs_s   = mon_tag_tvalid && mon_tag_tready;

    // Zero-latency ciphertext path; only byte 0 of an injected first beat changes.
    assign m_c.tvalid = s_c.tvalid;
    assign s_c.tready = m_c.tready;
    assign m_c.tlast  = s_c.tlast;
    assign m_c.tkeep  = s_c.tkeep;
    assign m_c.tdata  = s_c.tdata ^ {{(DW-8){1'b0}}, (corrupt_s ? mask_r : 8'h00)};

    axis_ascon_aead128_roundtrip_checker_fifo #(.W(SBW), .AW(DEPTH_LOG2)) u_sb (
        .clk       (clk),
        .resetn    (resetn),
        .push      (p_hs_s),
        .push_data ({mon_p.tlast, mon_p.tdata, mon_p.tkeep}),
        .pop       (d_hs_s),
        .head_data (sb_head_s),
        .overflow  (sb_ovf_s),
        .underflow (sb_und_s)
    );

    axis_ascon_aead128_roundtrip_checker_fifo #(.W(1), .AW(DEPTH_LOG2)) u_flag (
        .clk       (clk),
        .resetn    (resetn),
        .push      (first_hs_s),
        .push_data (flag_in_s),
        .pop       (tag_hs_s),
        .head_data (flag_head_s),
        .overflow  (fl_ovf_s),
        .underflow (fl_und_s)
    );

    // Message-boundary next state from ciphertext handshakes.
    always_comb begin
        c_state_s = c_state_r;
        case (c_state_r)
            C_IDLE: begin
                if (c_hs_s && !s_c.tlast) begin
                    c_state_s = C_BODY;
                end else begin
                    c_state_s = C_IDLE;
                end
            end
            C_BODY: begin
                if (c_hs_s && s_c.tlast) begin
                    c_state_s = C_IDLE;
                end else begin
                    c_state_s = C_BODY;
                end
            end
            default: c_state_s = C_IDLE;
        endcase
    end

    // Beat comparison and per-message verdict.
    always_comb begin
        mismatch_s = 1'b0;
        tag_pass_s = 1'b0;
        if (d_hs_s) begin
            mismatch_s = sb_und_s ||
                         (!flag_head_s && beat_differs(sb_head_s, mon_d.tlast, mon_d.tdata, mon_d.tkeep));
        end else begin
            mismatch_s = 1'b0;
        end
        if (fl_und_s) begin
            tag_pass_s = 1'b0;
        end else if (flag_head_s) begin
            tag_pass_s = (mon_tag_tdata != 128'd0);
        end else begin
            tag_pass_s = (mon_tag_tdata == 128'd0) && !msg_bad_r;
        end
    end

    // Message-boundary state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_state_r <= C_IDLE;
        end else begin
            c_state_r <= c_state_s;
        end
    end

    // Injection request latch; a new request wins over the first-beat clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inj_pending_r <= 1'b0;
            mask_r        <= 8'h00;
        end else if (inj_req) begin
            inj_pending_r <= 1'b1;
            mask_r        <= inj_mask;
        end else if (first_hs_s) begin
            inj_pending_r <= 1'b0;
        end
    end

    // Per-message mismatch accumulator, restarted by the tag handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            msg_bad_r <= 1'b0;
        end else if (tag_hs_s) begin
            msg_bad_r <= mismatch_s;
        end else begin
            msg_bad_r <= msg_bad_r | mismatch_s;
        end
    end

    // Saturating outcome counters and sticky queue error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pass_cnt     <= {CNT_W{1'b0}};
            fail_cnt     <= {CNT_W{1'b0}};
            sb_overflow  <= 1'b0;
            sb_underflow <= 1'b0;
        end else begin
            if (tag_hs_s && tag_pass_s && (pass_cnt != CNT_MAX)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (tag_hs_s && !tag_pass_s && (fail_cnt != CNT_MAX)) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
            sb_overflow  <= sb_overflow  | sb_ovf_s | fl_ovf_s;
            sb_underflow <= sb_underflow | sb_und_s | fl_und_s;
        end
    end
endmodule

// File: tb/tb_axis_ascon_aead128_roundtrip_checker.sv
// Directed bench for the Ascon-AEAD128 round-trip checker: a vector table of
// single-beat messages plus hand-written multi-beat, queue-limit and reset cases.
module tb_axis_ascon_aead128_roundtrip_checker;
    localparam logic [127:0] C  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] P  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] P3 = 128'h00112233_44556677_8899AABB_33DDEEFF;

    logic         clk;
    logic         resetn;
    logic         mon_tag_tvalid;
    logic         mon_tag_tready;
    logic [127:0] mon_tag_tdata;
    logic         inj_req;
    logic [7:0]   inj_mask;
    logic [15:0]  pass_cnt;
    logic [15:0]  fail_cnt;
    logic         sb_overflow;
    logic         sb_underflow;

    int n_checks;
    int n_fail;
    int exp_pass;
    int exp_fail;

    axis_ascon_aead128_roundtrip_checker_if #(.DW(128)) mon_p_if ();
    axis_ascon_aead128_roundtrip_checker_if #(.DW(128)) s_c_if ();
    axis_ascon_aead128_roundtrip_checker_if #(.DW(128)) m_c_if ();
    axis_ascon_aead128_roundtrip_checker_if #(.DW(128)) mon_d_if ();

    axis_ascon_aead128_roundtrip_checker #(.DW(128), .DEPTH_LOG2(2), .CNT_W(16)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mon_p          (mon_p_if),
        .s_c            (s_c_if),
        .m_c            (m_c_if),
        .mon_d          (mon_d_if),
        .mon_tag_tvalid (mon_tag_tvalid),
        .mon_tag_tready (mon_tag_tready),
        .mon_tag_tdata  (mon_tag_tdata),
        .inj_req        (inj_req),
        .inj_mask       (inj_mask),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .sb_overflow    (sb_overflow),
        .sb_underflow   (sb_underflow)
    );

    typedef struct {
        string        name;
        logic         inj;
        logic [7:0]   mask;
        logic [127:0] exp_c;
        logic [15:0]  pkeep;
        logic [127:0] ddata;
        logic [15:0]  dkeep;
        logic         dlast;
        logic [127:0] tag;
        logic         exp_pass;
    } vec_t;

    vec_t vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string name);
        check({name, "_pass"}, 128'(pass_cnt), 128'(exp_pass));
        check({name, "_fail"}, 128'(fail_cnt), 128'(exp_fail));
    endtask

    task automatic inj(input logic [7:0] m);
        @(negedge clk);
        inj_req  = 1'b1;
        inj_mask = m;
        @(posedge clk); #1;
        inj_req  = 1'b0;
        inj_mask = 8'h00;
    endtask

    task automatic c_beat(input string name, input logic [127:0] data, input logic last,
                          input logic [127:0] exp, input logic do_inj, input logic [7:0] m);
        @(negedge clk);
        s_c_if.tvalid = 1'b1;
        s_c_if.tdata  = data;
        s_c_if.tkeep  = 16'hFFFF;
        s_c_if.tlast  = last;
        m_c_if.tready = 1'b1;
        inj_req       = do_inj;
        inj_mask      = m;
        #1;
        check({name, "_cdata"}, m_c_if.tdata, exp);
        check({name, "_cvalid_ready"}, {126'd0, m_c_if.tvalid, s_c_if.tready}, 128'd3);
        @(posedge clk); #1;
        s_c_if.tvalid = 1'b0;
        inj_req       = 1'b0;
        inj_mask      = 8'h00;
    endtask

    task automatic p_beat(input logic [127:0] data, input logic [15:0] keep, input logic last);
        @(negedge clk);
        mon_p_if.tvalid = 1'b1;
        mon_p_if.tready = 1'b1;
        mon_p_if.tdata  = data;
        mon_p_if.tkeep  = keep;
        mon_p_if.tlast  = last;
        @(posedge clk); #1;
        mon_p_if.tvalid = 1'b0;
    endtask

    task automatic d_beat(input logic [127:0] data, input logic [15:0] keep, input logic last);
        @(negedge clk);
        mon_d_if.tvalid = 1'b1;
        mon_d_if.tready = 1'b1;
        mon_d_if.tdata  = data;
        mon_d_if.tkeep  = keep;
        mon_d_if.tlast  = last;
        @(posedge clk); #1;
        mon_d_if.tvalid = 1'b0;
    endtask

    task automatic tag(input logic [127:0] t);
        @(negedge clk);
        mon_tag_tvalid = 1'b1;
        mon_tag_tready = 1'b1;
        mon_tag_tdata  = t;
        @(posedge clk); #1;
        mon_tag_tvalid = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_pass = 0; exp_fail = 0;
        resetn = 1'b0;
        mon_tag_tvalid = 1'b0; mon_tag_tready = 1'b0; mon_tag_tdata = 128'd0;
        inj_req = 1'b0; inj_mask = 8'h00;
        mon_p_if.tvalid = 1'b0; mon_p_if.tready = 1'b0; mon_p_if.tlast = 1'b0;
        mon_p_if.tdata = 128'd0; mon_p_if.tkeep = 16'd0;
        mon_d_if.tvalid = 1'b0; mon_d_if.tready = 1'b0; mon_d_if.tlast = 1'b0;
        mon_d_if.tdata = 128'd0; mon_d_if.tkeep = 16'd0;
        s_c_if.tvalid = 1'b0; s_c_if.tlast = 1'b0; s_c_if.tdata = 128'd0; s_c_if.tkeep = 16'd0;
        m_c_if.tready = 1'b1;

        //             name        inj   mask   exp_c                                        pkeep     ddata  dkeep     dlast tag            pass
        vecs[0] = '{"clean",      1'b0, 8'h00, C,                                           16'hFFFF, P,     16'hFFFF, 1'b1, 128'd0,        1'b1};
        vecs[1] = '{"mask00",     1'b1, 8'h00, C,                                           16'hFFFF, P,     16'hFFFF, 1'b1, 128'd0,        1'b1};
        vecs[2] = '{"b3_kept",    1'b0, 8'h00, C,                                           16'hFFFF, P3,    16'hFFFF, 1'b1, 128'd0,        1'b0};
        vecs[3] = '{"b3_masked",  1'b0, 8'h00, C,                                           16'hFFF7, P3,    16'hFFF7, 1'b1, 128'd0,        1'b1};
        vecs[4] = '{"tag_bad",    1'b0, 8'h00, C,                                           16'hFFFF, P,     16'hFFFF, 1'b1, 128'd1,        1'b0};
        vecs[5] = '{"inj_caught", 1'b1, 8'h3C, 128'h0123456789ABCDEF_FEDCBA987654322C,      16'hFFFF, ~P,    16'hFFFF, 1'b1, 128'hDEAD,     1'b1};
        vecs[6] = '{"inj_missed", 1'b1, 8'h3C, 128'h0123456789ABCDEF_FEDCBA987654322C,      16'hFFFF, P,     16'hFFFF, 1'b1, 128'd0,        1'b0};
        vecs[7] = '{"last_diff",  1'b0, 8'h00, C,                                           16'hFFFF, P,     16'hFFFF, 1'b0, 128'd0,        1'b0};
        vecs[8] = '{"keep_diff",  1'b0, 8'h00, C,                                           16'hFFFF, P,     16'h7FFF, 1'b1, 128'd0,        1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_counts("reset");
        check("reset_flags", {126'd0, sb_overflow, sb_underflow}, 128'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Table of single-beat messages.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].inj) begin
                inj(vecs[i].mask);
            end
            c_beat(vecs[i].name, C, 1'b1, vecs[i].exp_c, 1'b0, 8'h00);
            p_beat(P, vecs[i].pkeep, 1'b1);
            d_beat(vecs[i].ddata, vecs[i].dkeep, vecs[i].dlast);
            tag(vecs[i].tag);
            if (vecs[i].exp_pass) exp_pass++;
            else exp_fail++;
            check_counts(vecs[i].name);
        end

        // Multi-beat injected message; second request overwrites mask, and a
        // request on the first beat only affects the following message.
        inj(8'h33);
        inj(8'h5A);
        c_beat("mb_b0", C, 1'b0, 128'h0123456789ABCDEF_FEDCBA987654324A, 1'b1, 8'h0F);
        c_beat("mb_b1", C, 1'b0, C, 1'b0, 8'h00);
        c_beat("mb_b2", C, 1'b1, C, 1'b0, 8'h00);
        p_beat(P, 16'hFFFF, 1'b0); p_beat(P, 16'hFFFF, 1'b0); p_beat(P, 16'hFFFF, 1'b1);
        d_beat(~P, 16'hFFFF, 1'b0); d_beat(~P, 16'hFFFF, 1'b0); d_beat(~P, 16'hFFFF, 1'b1);
        tag(128'h5);
        exp_pass++;
        check_counts("mb");
        c_beat("next_msg", C, 1'b1, 128'h0123456789ABCDEF_FEDCBA987654321F, 1'b0, 8'h00);
        p_beat(P, 16'hFFFF, 1'b1);
        d_beat(~P, 16'hFFFF, 1'b1);
        tag(128'h1);
        exp_pass++;
        check_counts("next_msg");
        check("no_err_flags", {126'd0, sb_overflow, sb_underflow}, 128'd0);

        // Scoreboard limits with a four-entry queue.
        for (int i = 0; i < 5; i++) begin
            p_beat(P ^ 128'(i), 16'hFFFF, 1'b0);
            if (i == 3) check("ovf_at_4", 128'(sb_overflow), 128'd0);
        end
        check("ovf_at_5", 128'(sb_overflow), 128'd1);
        for (int i = 0; i < 4; i++) begin
            d_beat(P ^ 128'(i), 16'hFFFF, 1'b0);
        end
        check("und_drained", 128'(sb_underflow), 128'd0);
        d_beat(P, 16'hFFFF, 1'b0);
        check("und_empty", 128'(sb_underflow), 128'd1);
        tag(128'd0);
        exp_fail++;
        check_counts("flag_empty");

        // Reset in the middle of a message with two beats queued.
        c_beat("pre_rst", C, 1'b0, C, 1'b0, 8'h00);
        p_beat(P, 16'hFFFF, 1'b0);
        p_beat(P3, 16'hFFFF, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        exp_pass = 0;
        exp_fail = 0;
        check_counts("in_rst");
        check("in_rst_flags", {126'd0, sb_overflow, sb_underflow}, 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        inj(8'h21);
        c_beat("post_rst", C, 1'b1, 128'h0123456789ABCDEF_FEDCBA9876543231, 1'b0, 8'h00);
        p_beat(P, 16'hFFFF, 1'b1);
        d_beat(~P, 16'hFFFF, 1'b1);
        tag(128'h7);
        exp_pass++;
        check_counts("post_rst");
        c_beat("post_rst2", C, 1'b1, C, 1'b0, 8'h00);
        p_beat(P, 16'hFFFF, 1'b1);
        d_beat(P, 16'hFFFF, 1'b1);
        tag(128'd0);
        exp_pass++;
        check_counts("post_rst2");
        check("post_rst_flags", {126'd0, sb_overflow, sb_underflow}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_ascon_aead128_roundtrip_checker.md
AXIS_ASCON_AEAD128_ROUNDTRIP_CHECKER -- requirements
Module: axis_ascon_aead128_roundtrip_checker

Interface
REQ-001 SHALL have parameter DW, default 128, data width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, log2 entries of data scoreboard and of message-flag queue.
REQ-003 SHALL have parameter CNT_W, default 16, width of status counters.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 mon_p_tvalid/tready/tlast  in  1 each  monitor of plaintext into encryptor.
REQ-008 mon_p_tdata  in  DW; mon_p_tkeep  in  DW/8  monitored plaintext beat.
REQ-009 s_c_tvalid  in  1; s_c_tready  out  1; s_c_tlast  in  1; s_c_tdata  in  DW; s_c_tkeep  in  DW/8  ciphertext from encryptor.
REQ-010 m_c_tvalid  out  1; m_c_tready  in  1; m_c_tlast  out  1; m_c_tdata  out  DW; m_c_tkeep  out  DW/8  ciphertext to decryptor.
REQ-011 mon_d_tvalid/tready/tlast  in  1 each; mon_d_tdata  in  DW; mon_d_tkeep  in  DW/8  monitor of decryptor plaintext output.
REQ-012 mon_tag_tvalid/tready  in  1 each; mon_tag_tdata  in  128  decryptor tag result (zero = authentic).
REQ-013 inj_req  in  1  single-cycle request to corrupt the next ciphertext message.
REQ-014 inj_mask  in  8  XOR mask, sampled with inj_req.
REQ-015 pass_cnt, fail_cnt  out  CNT_W each  message outcome counters.
REQ-016 sb_overflow, sb_underflow  out  1 each  sticky scoreboard error flags.

Function
REQ-017 Ciphertext path SHALL be combinational: m_c_tvalid=s_c_tvalid, s_c_tready=m_c_tready, tlast/tkeep unchanged; zero latency.
REQ-018 m_c_tdata SHALL equal s_c_tdata except bits [7:0] XOR stored mask on first beat of an injected message.
REQ-019 Message-boundary FSM states: C_IDLE (awaiting first beat), C_BODY; C_IDLE->C_BODY on handshake with tlast=0; C_BODY->C_IDLE on handshake with tlast=1; single-beat message stays C_IDLE.
REQ-020 inj_req SHALL set inj_pending and latch mask; a second inj_req while pending overwrites mask.
REQ-021 On first-beat handshake in C_IDLE, SHALL push flag (inj_pending && mask!=0) into flag queue and clear inj_pending; inj_req same cycle applies to following message.
REQ-022 Scoreboard SHALL push {tlast,tdata,tkeep} on mon_p handshake, pop on mon_d handshake; simultaneous push/pop allowed when full or empty-with-push (pop-empty is underflow only if nothing pushed same cycle and count=0).
REQ-023 Push when full (without same-cycle pop) SHALL drop entry and set sb_overflow.
REQ-024 Pop when empty SHALL set sb_underflow; beat marked mismatched.
REQ-025 Per message, SHALL hold msg_bad: set if popped entry differs from mon_d beat in tlast, tkeep, or any tdata byte whose tkeep bit is set; cleared after tag handshake.
REQ-026 For head flag=1, data comparison SHALL be ignored; entries still popped.
REQ-027 On mon_tag handshake: pop flag queue; pass if (flag=0, tag==0, !msg_bad) or (flag=1, tag!=0); otherwise fail; flag queue empty counts as fail and sets sb_underflow.
REQ-028 Flag queue full on push SHALL set sb_overflow and drop flag.
REQ-029 pass_cnt/fail_cnt SHALL saturate at 2^CNT_W-1.

Reset
REQ-030 resetn low SHALL immediately clear both queues, FSM to C_IDLE, inj_pending, mask, msg_bad, counters, sticky flags; m_c_tdata reverts to pass-through.
REQ-031 Reset mid-message SHALL discard partial messages; first handshake after release is a first beat.

Verification
REQ-032 Clean single-beat message, key/nonce arbitrary, tag=0 -> pass_cnt=1, fail_cnt=0, m_c_tdata==s_c_tdata.
REQ-033 inj_req with mask 0x5A, then 3-beat message -> beat0 m_c_tdata[7:0]=s_c_tdata[7:0]^0x5A, beats 1-2 unchanged; tag nonzero -> pass_cnt=1.
REQ-034 inj_req with mask 0x00 -> no corruption, flag 0; tag=0 and data matching -> pass.
REQ-035 Decrypted byte 3 differs with tkeep[3]=1 -> fail_cnt=1; same with tkeep[3]=0 -> pass.
REQ-036 DEPTH_LOG2=2, push 5 beats with mon_d stalled -> sb_overflow=1 on 5th; mon_d beat with empty queue -> sb_underflow=1.
REQ-037 resetn low during C_BODY with 2 entries queued -> counters 0, queues empty, next beat treated as first beat.
